// File: rtl/bit_iter_pkg.sv
// Shared opcodes, iterative-op selectors and FSM state encoding for the
// bit-iterative ALU.
package bit_iter_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_SHH  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_POPC = 4'b1000;
  localparam logic [3:0] OP_RUN  = 4'b1001;
  localparam logic [3:0] OP_SETZ = 4'b1010;
  localparam logic [3:0] OP_CLZ  = 4'b1011;

  // Low two opcode bits select the accumulator behaviour of an iterative op.
  localparam logic [1:0] IT_POPC = 2'b00;
  localparam logic [1:0] IT_RUN  = 2'b01;
  localparam logic [1:0] IT_SETZ = 2'b10;
  localparam logic [1:0] IT_CLZ  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/bit_iter_slice.sv
// One step of the iterative ops: folds BPC operand bits (LSB first) into the
// popcount / run / set-zero / clz accumulators.
module bit_iter_slice
  import bit_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [1:0]       sel,
  input  logic [BPC-1:0]   a_bits,
  input  logic [BPC-1:0]   b_bits,
  input  logic [WIDTH-1:0] b_full,
  input  logic [CW-1:0]    cnt_i,
  input  logic [CW-1:0]    run_i,
  input  logic [CW-1:0]    best_i,
  output logic [CW-1:0]    cnt_o,
  output logic [CW-1:0]    run_o,
  output logic [CW-1:0]    best_o,
  output logic [BPC-1:0]   set_o
);

  always_comb begin
    cnt_o  = cnt_i;
    run_o  = run_i;
    best_o = best_i;
    set_o  = '0;
    for (int i = 0; i < BPC; i++) begin
      case (sel)
        IT_POPC: if (a_bits[i] & b_bits[i]) cnt_o = cnt_o + CW'(1);
        IT_RUN: begin
          if (a_bits[i]) begin
            run_o = run_o + CW'(1);
            if (run_o > best_o) best_o = run_o;
          end else begin
            run_o = '0;
          end
        end
        IT_SETZ: begin
          // cnt counts zeros already set; compared against all of B
          set_o[i] = a_bits[i];
          if (!a_bits[i] && (WIDTH'(cnt_o) < b_full)) begin
            set_o[i] = 1'b1;
            cnt_o    = cnt_o + CW'(1);
          end
        end
        default: begin
          // zero run above the most recent 1 is the leading-zero count
          if (a_bits[i]) cnt_o = '0;
          else           cnt_o = cnt_o + CW'(1);
        end
      endcase
    end
  end

endmodule

// File: rtl/bit_iter_alu.sv
// Small ALU: single-cycle arithmetic/logic ops plus fixed-latency bit-serial
// ops that walk the operands BPC bits per cycle.
module bit_iter_alu
  import bit_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [WIDTH-1:0]         src_a,
  input  logic [WIDTH-1:0]         src_b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result
);

  localparam int SW    = $clog2(WIDTH);
  localparam int CW    = SW + 1;
  localparam int NSTEP = WIDTH / BPC;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SW-1:0]    shamt;
  } req_t;

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [CW-1:0]    step_q, step_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    run_q, run_d;
  logic [CW-1:0]    best_q, best_d;
  logic [WIDTH-1:0] setz_q, setz_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] a_win, b_win;
  logic [BPC-1:0]   a_bits, b_bits;
  logic [CW-1:0]    s_cnt, s_run, s_best;
  logic [BPC-1:0]   s_set;
  int               idx;

  // Start is only honoured outside RUN; captured operands drive everything after.
  assign accept = start && (state_q != ST_RUN);
  assign req_d  = accept ? '{op: op, a: src_a, b: src_b, shamt: shamt} : req_q;

  always_comb begin
    alu_res = '0;
    case (req_d.op)
      OP_ADD:  alu_res = req_d.a + req_d.b;
      OP_SUB:  alu_res = req_d.a - req_d.b;
      OP_OR:   alu_res = req_d.a | req_d.b;
      OP_SHH:  alu_res = req_d.b << (WIDTH / 2);
      OP_SHL:  alu_res = req_d.b << req_d.shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(req_d.a) < $signed(req_d.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (req_d.a < req_d.b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    idx    = int'(step_q) * BPC;
    a_win  = req_q.a >> idx;
    b_win  = req_q.b >> idx;
    a_bits = a_win[BPC-1:0];
    b_bits = b_win[BPC-1:0];
  end

  bit_iter_slice #(.WIDTH(WIDTH), .BPC(BPC), .CW(CW)) u_slice (
    .sel    (req_q.op[1:0]),
    .a_bits (a_bits),
    .b_bits (b_bits),
    .b_full (req_q.b),
    .cnt_i  (cnt_q),
    .run_i  (run_q),
    .best_i (best_q),
    .cnt_o  (s_cnt),
    .run_o  (s_run),
    .best_o (s_best),
    .set_o  (s_set)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    best_d   = best_q;
    setz_d   = setz_q;
    result_d = result_q;
    case (state_q)
      ST_RUN: begin
        // abort wins over a same-cycle completion
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d            = s_cnt;
          run_d            = s_run;
          best_d           = s_best;
          setz_d[idx +: BPC] = s_set;
          step_d           = step_q + CW'(1);
          if (step_q == LAST) begin
            state_d = ST_DONE;
            case (req_q.op[1:0])
              IT_POPC: result_d = WIDTH'(s_cnt);
              IT_RUN:  result_d = WIDTH'(s_best);
              IT_SETZ: result_d = setz_d;
              default: result_d = WIDTH'(s_cnt);
            endcase
          end
        end
      end
      default: begin
        if (accept) begin
          step_d = '0;
          cnt_d  = '0;
          run_d  = '0;
          best_d = '0;
          setz_d = '0;
          if (is_iter_op(req_d.op)) begin
            state_d = ST_RUN;
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
      run_q    <= '0;
      best_q   <= '0;
      setz_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      best_q   <= best_d;
      setz_q   <= setz_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: doc/bit_iter_alu.md
BIT_ITER_ALU -- requirements
Module: bit_iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8..64, power of two.
REQ-002 SHALL have parameter BPC, default 1, bits processed per cycle by iterative ops; must divide WIDTH.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-004 SHALL have ports: start  in  1  request, sampled only when busy=0; op  in  4  operation code; src_a  in  WIDTH  operand A; src_b  in  WIDTH  operand B.
REQ-005 SHALL have ports: shamt  in  $clog2(WIDTH)  shift amount; abort  in  1  synchronous cancel of an in-flight operation.
REQ-006 SHALL have ports: busy  out  1  iterative op in progress; done  out  1  one-cycle completion pulse; result  out  WIDTH  last completed result, held until the next completion.

Function
REQ-007 SHALL implement an FSM with states IDLE, RUN, DONE; RUN is used only by iterative ops.
REQ-008 SHALL accept start in IDLE or DONE; SHALL ignore start in RUN, with no operand capture and no effect on the running op.
REQ-009 SHALL register op, src_a, src_b and shamt at acceptance; later input changes SHALL NOT affect the accepted op.
REQ-010 SHALL treat op 0000..0110 as single-cycle ops: add; sub; or; B<<(WIDTH/2); B<<shamt; signed A<B; unsigned A<B. Compare results SHALL be 1 or 0, zero-extended.
REQ-011 SHALL treat op 1000..1011 as iterative ops: popcount(A&B); longest run of consecutive 1s in A; set the lowest min(B, zeros(A)) zero bits of A, LSB upward; count leading zeros of A (A=0 gives WIDTH).
REQ-012 SHALL treat any other op as a single-cycle op with result 0.
REQ-013 SHALL complete a single-cycle op accepted at edge k with result loaded and done=1 in the cycle after edge k; busy SHALL stay 0.
REQ-014 SHALL enter RUN at acceptance of an iterative op at edge k; edges k+1..k+WIDTH/BPC SHALL each process BPC bits LSB-first; busy=1 throughout RUN.
REQ-015 SHALL load result, enter DONE and assert done for exactly one cycle after edge k+WIDTH/BPC; total latency is WIDTH/BPC+1 cycles, fixed and independent of data.
REQ-016 SHALL return DONE to IDLE on the next edge unless start is asserted; start in DONE SHALL be accepted back-to-back.
REQ-017 SHALL size internal counters to $clog2(WIDTH)+1 bits so that all-ones inputs do not wrap; counting results SHALL be zero-extended to WIDTH.
REQ-018 SHALL compare op 1010 against the full WIDTH-bit value of B; when B >= zeros(A), the result SHALL equal all ones.
REQ-019 SHALL, on abort=1 in RUN, go to IDLE at the next edge with no done pulse and result unchanged; abort SHALL take priority over completion in the same cycle.
REQ-020 SHALL ignore abort in IDLE and DONE.

Reset
REQ-021 SHALL, on reset=0, immediately force state=IDLE, busy=0, done=0, result=0 and clear all counters, independent of clk.
REQ-022 SHALL, on reset during RUN, discard the in-flight op; no done pulse SHALL follow reset release.
REQ-023 SHALL accept no start until the first rising edge after reset deasserts.

Structure
REQ-024 SHALL place opcode constants (OP_ADD..OP_CLZ) and FSM state encodings in shared package bit_iter_pkg.
REQ-025 SHALL implement the per-cycle BPC-bit update of the popcount, run, set-zero and clz accumulators in one combinational sub-module, bit_iter_slice.
REQ-026 SHALL keep the single-cycle datapath and the FSM in bit_iter_alu.

Verification (WIDTH=32, BPC=1 unless stated)
REQ-027 SHALL cover popcount: op=1000, A=F0F0F0F0, B=FF00FF00 -> busy for 32 cycles, done at cycle 33, result=8.
REQ-028 SHALL cover longest run and set-zero: op=1001, A=0FF00F00 -> 8; op=1010, A=FFFFFFF0, B=2 -> FFFFFFF3; B=100 -> FFFFFFFF.
REQ-029 SHALL cover clz: op=1011, A=00010000 -> 15; A=0 -> 32; repeat with BPC=4, which must give identical results in 9 cycles.
REQ-030 SHALL cover single-cycle ops: op=0101, A=FFFFFFFF, B=1 -> result=1, done the next cycle, busy never set; op=1111 -> result 0.
REQ-031 SHALL cover handshake: start with new operands at cycle 5 of a run -> ignored, original result; start in the DONE cycle -> accepted back-to-back.
REQ-032 SHALL cover abort and reset: abort at cycle 10 of a run -> IDLE, no done, old result kept; reset=0 mid-run -> outputs zero immediately, no done after release.
